mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: MEM_LATENCY, default 4, memory read/write latency in cycles (legal 1..15).
REQ-002 SHALL have ports as follows.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  instruction-fetch read request.
- if_addr  input  32  fetch byte address.
- if_ack  output  1  one-cycle fetch completion pulse.
- if_rdata  output  32  fetched word.
- d_req  input  1  data request.
- d_we  input  1  data write (1) / read (0).
- d_addr  input  32  data byte address.
- d_wdata  input  32  store word.
- d_ack  output  1  one-cycle data completion pulse.
- d_rdata  output  32  loaded word.
- mem_addr  output  32  shared memory address.
- mem_data_in  output  4x8  bytes to memory; byte k = word bits [8k+7:8k].
- mem_data_out  input  4x8  bytes from memory, same ordering.
- mem_write_en  output  1  memory write strobe.
- busy  output  1  high whenever a transaction is in progress; drives core stall.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-004 In IDLE, SHALL sample if_req and d_req at each rising edge; if either is high, SHALL latch owner, word address, we, and wdata, clear counter to 0, and go to BUSY.
REQ-005 SHALL arbitrate round-robin: one requester alone wins; on simultaneous requests, the requester not granted last wins.
REQ-006 SHALL force we=0 on fetch grants; fetch is read-only.
REQ-007 SHALL drive mem_addr = {latched_addr[31:2],2'b00} in BUSY and DONE, and 0 in IDLE.
REQ-008 SHALL drive mem_data_in from latched wdata in BUSY; otherwise mem_data_in SHALL be 0.
REQ-009 SHALL assert mem_write_en only in the first BUSY cycle (counter==0) of a write transaction.
REQ-010 In BUSY, SHALL increment counter each cycle; at counter==MEM_LATENCY-1 SHALL go to DONE, and on a read SHALL capture mem_data_out into the owner's rdata register.
REQ-011 In DONE, SHALL assert exactly the owner's ack for one cycle, update last-owner, and go to IDLE unconditionally.
REQ-012 SHALL give ack in cycle MEM_LATENCY+1 when req is sampled in cycle 0, i.e. cycle 5 at default.
REQ-013 SHALL not sample requests in DONE; minimum spacing between grants is MEM_LATENCY+2 cycles.
REQ-014 if_rdata and d_rdata SHALL be registered and SHALL hold until the next read by the same requester completes; a write SHALL leave d_rdata unchanged.
REQ-015 Requester inputs changed after grant SHALL be ignored; the latched values SHALL be used.
REQ-016 A req dropped after grant SHALL not abort the transaction; ack is still issued.
REQ-017 busy SHALL equal (state != IDLE).

Reset
REQ-018 reset high SHALL immediately set state=IDLE, counter=0, last-owner=IF, and all outputs to 0 (if_ack, d_ack, busy, mem_write_en, mem_addr, mem_data_in, if_rdata, d_rdata).
REQ-019 reset asserted mid-transaction SHALL abort with no ack and no further mem_write_en; after release, the first tie SHALL go to data.

Verification
REQ-020 Lone fetch: if_req=1, if_addr=0x103, memory returns 0xDEADBEEF -> mem_addr=0x100 in cycles 1-5; if_ack=1 in cycle 5; if_rdata=0xDEADBEEF; busy high cycles 1-5.
REQ-021 Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x11223344 -> mem_write_en=1 in cycle 1 only; mem_data_in bytes {44,33,22,11}; d_ack in cycle 5; d_rdata unchanged.
REQ-022 Tie after reset: if_req=d_req=1 held -> data granted first (d_ack cycle 5), then fetch granted in cycle 6 (if_ack cycle 11), then data again.
REQ-023 Reset in cycle 3 of a write -> busy=0 and mem_write_en=0 immediately; no ack; next request gets a normal latency of MEM_LATENCY+1.
REQ-024 MEM_LATENCY=1 -> single BUSY cycle, ack in cycle 2; address change after grant does not affect mem_addr.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one fixed-latency memory between fetch and data ports.
module mem_arbiter #(
   parameter int MEM_LATENCY = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_req,
   input  logic [31:0]      if_addr,
   output logic             if_ack,
   output logic [31:0]      if_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [31:0]      d_addr,
   input  logic [31:0]      d_wdata,
   output logic             d_ack,
   output logic [31:0]      d_rdata,
   output logic [31:0]      mem_addr,
   output logic [3:0][7:0]  mem_data_in,
   input  logic [3:0][7:0]  mem_data_out,
   output logic             mem_write_en,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t      state;
   logic [3:0]  cnt;
   logic        own_d, last_d, we;
   logic [29:0] addr;
   logic [31:0] wdata;
   logic        grant_d;
   // data wins when alone, or on a tie when fetch was served last
   assign grant_d = d_req & (~if_req | ~last_d);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         own_d    <= 1'b0;
         last_d   <= 1'b0;
         we       <= 1'b0;
         addr     <= '0;
         wdata    <= '0;
         if_ack   <= 1'b0;
         d_ack    <= 1'b0;
         if_rdata <= '0;
         d_rdata  <= '0;
      end else begin
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         case (state)
            IDLE: if (if_req | d_req) begin
               own_d <= grant_d;
               we    <= grant_d & d_we;
               addr  <= grant_d ? d_addr[31:2] : if_addr[31:2];
               wdata <= grant_d ? d_wdata : '0;
               cnt   <= '0;
               state <= BUSY;
            end
            BUSY: begin
               cnt <= cnt + 4'd1;
               if (cnt == 4'(MEM_LATENCY - 1)) begin
                  state  <= DONE;
                  if_ack <= ~own_d;
                  d_ack  <= own_d;
                  if (!we && own_d) d_rdata <= mem_data_out;
                  if (!we && !own_d) if_rdata <= mem_data_out;
               end
            end
            DONE: begin
               last_d <= own_d;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign busy         = state != IDLE;
   assign mem_addr     = busy ? {addr, 2'b00} : '0;
   assign mem_data_in  = (state == BUSY) ? wdata : '0;
   assign mem_write_en = (state == BUSY) && cnt == 4'd0 && we;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at default latency and at latency 1.
module tb_mem_arbiter;
   logic clk = 0, reset = 1;
   logic if_req = 0, d_req = 0, d_we = 0;
   logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
   logic [3:0][7:0] mem_data_out = '0;
   logic if_ack, d_ack, mem_write_en, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr;
   logic [3:0][7:0] mem_data_in;
   logic q_if_req = 0;
   logic [31:0] q_if_addr = 0;
   logic [3:0][7:0] q_mem_data_out = '0;
   logic q_if_ack, q_d_ack, q_mem_write_en, q_busy;
   logic [31:0] q_if_rdata, q_d_rdata, q_mem_addr;
   logic [3:0][7:0] q_mem_data_in;
   int nchk = 0, nerr = 0;
   always #5 clk = ~clk;
   mem_arbiter u0 (.clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
      .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .mem_write_en(mem_write_en), .busy(busy));
   mem_arbiter #(.MEM_LATENCY(1)) u1 (.clk(clk), .reset(reset), .if_req(q_if_req), .if_addr(q_if_addr),
      .if_ack(q_if_ack), .if_rdata(q_if_rdata), .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0),
      .d_wdata(32'd0), .d_ack(q_d_ack), .d_rdata(q_d_rdata), .mem_addr(q_mem_addr),
      .mem_data_in(q_mem_data_in), .mem_data_out(q_mem_data_out), .mem_write_en(q_mem_write_en),
      .busy(q_busy));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      tick;
      tick;
      check("rst_busy", 32'(busy), 0);
      check("rst_addr", mem_addr, 0);
      check("rst_acks", {if_ack, d_ack, mem_write_en}, 0);
      check("rst_rdata", if_rdata | d_rdata, 0);
      reset = 0;
      // lone fetch
      if_req = 1; if_addr = 32'h103; mem_data_out = 32'hDEADBEEF;
      for (int c = 1; c <= 5; c++) begin
         tick;
         if_req = 0; if_addr = 32'hFFF;
         check($sformatf("if_addr_c%0d", c), mem_addr, 32'h100);
         check($sformatf("if_busy_c%0d", c), 32'(busy), 1);
         check($sformatf("if_ack_c%0d", c), 32'(if_ack), 32'(c == 5));
      end
      check("if_rdata", if_rdata, 32'hDEADBEEF);
      tick;
      check("if_idle_busy", 32'(busy), 0);
      check("if_idle_addr", mem_addr, 0);
      // data read, then store that must not disturb d_rdata
      d_req = 1; d_we = 0; d_addr = 32'h40; mem_data_out = 32'hCAFEF00D;
      tick;
      d_req = 0;
      repeat (4) tick;
      check("ld_ack", 32'(d_ack), 1);
      check("ld_rdata", d_rdata, 32'hCAFEF00D);
      tick;
      d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h11223344; mem_data_out = 32'h55555555;
      for (int c = 1; c <= 5; c++) begin
         tick;
         d_req = 0; d_wdata = 0;
         check($sformatf("st_we_c%0d", c), 32'(mem_write_en), 32'(c == 1));
         check($sformatf("st_ack_c%0d", c), 32'(d_ack), 32'(c == 5));
         if (c == 1) begin
            check("st_din", mem_data_in, 32'h11223344);
            check("st_byte0", 32'(mem_data_in[0]), 32'h44);
            check("st_byte3", 32'(mem_data_in[3]), 32'h11);
            check("st_addr", mem_addr, 32'h20);
         end
      end
      check("st_rdata_kept", d_rdata, 32'hCAFEF00D);
      check("st_if_kept", if_rdata, 32'hDEADBEEF);
      tick;
      check("st_din_idle", mem_data_in, 0);
      // reset in cycle 3 of a write
      d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'hA5A5A5A5;
      tick;
      d_req = 0;
      check("ab_we_c1", 32'(mem_write_en), 1);
      tick;
      tick;
      reset = 1;
      #1;
      check("ab_busy", 32'(busy), 0);
      check("ab_we", 32'(mem_write_en), 0);
      check("ab_addr", mem_addr, 0);
      check("ab_ack", {if_ack, d_ack}, 0);
      check("ab_rdata", d_rdata, 0);
      tick;
      reset = 0;
      // held tie after reset: data, fetch, data
      if_req = 1; d_req = 1; d_we = 0; if_addr = 32'h200; d_addr = 32'h300; mem_data_out = 32'h0BADCAFE;
      for (int c = 1; c <= 17; c++) begin
         tick;
         check($sformatf("tie_dack_c%0d", c), 32'(d_ack), 32'(c == 5 || c == 17));
         check($sformatf("tie_iack_c%0d", c), 32'(if_ack), 32'(c == 11));
         if (c == 7) check("tie_if_addr", mem_addr, 32'h200);
         if (c == 13) check("tie_d_addr", mem_addr, 32'h300);
      end
      check("tie_if_rdata", if_rdata, 32'h0BADCAFE);
      check("tie_d_rdata", d_rdata, 32'h0BADCAFE);
      if_req = 0; d_req = 0;
      tick;
      tick;
      // latency 1
      q_if_req = 1; q_if_addr = 32'h44; q_mem_data_out = 32'h12345678;
      tick;
      q_if_req = 0; q_if_addr = 32'h88;
      check("l1_busy_c1", 32'(q_busy), 1);
      check("l1_addr_c1", q_mem_addr, 32'h44);
      check("l1_ack_c1", 32'(q_if_ack), 0);
      tick;
      check("l1_ack_c2", 32'(q_if_ack), 1);
      check("l1_addr_c2", q_mem_addr, 32'h44);
      check("l1_rdata", q_if_rdata, 32'h12345678);
      tick;
      check("l1_busy_c3", 32'(q_busy), 0);
      check("l1_ack_c3", 32'(q_if_ack), 0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
